debouncer: RTL and testbench

- Single-bit debounce filter for mechanical switch and push-button inputs, such as the board-level reset button.
- It runs on one slow clock (typically 10 MHz).
- The raw input is optionally synchronized into that clock domain.
- A change is passed to Out only after the new level has been held continuously for 2^Width enabled cycles.
- Single-cycle Rise/Fall pulses accompany every accepted transition.

---
 rtl/debouncer.sv | 94 +++++++++
 tb/tb_debouncer.sv | 117 +++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Single-bit debounce filter: a new input level reaches Out only after it has been
// held for 2^Width enabled cycles. Optional input synchronizer: define DEBOUNCE_SYNC_EN.
module debouncer #(
    parameter int Width = 20
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic In,
    output logic Out,
    output logic Rise,
    output logic Fall
);

    localparam logic [Width-1:0] CNT_ZERO = {Width{1'b0}};
    localparam logic [Width-1:0] CNT_ONE  = {{(Width-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0] CNT_MAX  = {Width{1'b1}};

    logic             sample_s;
    logic [Width-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchronizer keeps sampling In regardless of Enable.
    always_comb begin
        sync1_d = In;
        sync2_d = sync1_q;
    end

    // Two-stage synchronizer registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample_s = sync2_q;
`else
    assign sample_s = In;
`endif

    // Stability counting: any agreement with Out restarts the hold time; the
    // terminal count always commits, so the counter never wraps.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (Enable) begin
            if (sample_s == out_q) begin
                cnt_d = CNT_ZERO;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                out_d  = sample_s;
                cnt_d  = CNT_ZERO;
                rise_d = sample_s;
                fall_d = ~sample_s;
            end
        end else begin
            cnt_d = cnt_q;
            out_d = out_q;
        end
    end

    // Counter, debounced level and edge pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q  <= CNT_ZERO;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign Out  = out_q;
    assign Rise = rise_q;
    assign Fall = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer with Width=4; expected edge numbers are worked out
// by hand for both the synchronized and direct-input builds.
module tb_debouncer;

`ifdef DEBOUNCE_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    localparam int LAT        = 16 + S;   // edges from In change to Out change
    localparam int FALL_EDGE  = 31 + S;   // 16th enabled mismatch with Enable 1,0,1,0...
    localparam int GLITCH_RISE = 27 + S;  // 16 mismatches after the glitch clears

    logic Clock, Reset, Enable, In;
    logic Out, Rise, Fall;
    int   n_asserts = 0;
    int   n_fail    = 0;

    debouncer #(.Width(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Enable(Enable),
        .In    (In),
        .Out   (Out),
        .Rise  (Rise),
        .Fall  (Fall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic e_out, input logic e_rise, input logic e_fall);
        chk({tag, ".out"},  Out,  e_out);
        chk({tag, ".rise"}, Rise, e_rise);
        chk({tag, ".fall"}, Fall, e_fall);
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        Reset  = 1'b0;
        Enable = 1'b1;
        In     = 1'b0;

        // Reset held for 3 cycles, then quiet input.
        repeat (3) begin
            @(negedge Clock);
            chk3("reset", 1'b0, 1'b0, 1'b0);
        end
        Reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk3("idle", 1'b0, 1'b0, 1'b0);
        end

        // Clean rise.
        In = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk3($sformatf("rise_e%0d", k), (k >= LAT), (k == LAT), 1'b0);
        end

        // Fall with Enable toggling 1,0,1,0 starting on the first edge.
        In = 1'b0;
        for (int k = 1; k <= FALL_EDGE + 2; k++) begin
            Enable = (k % 2 == 1);
            tick();
            chk3($sformatf("fall_en_e%0d", k), (k < FALL_EDGE), 1'b0, (k == FALL_EDGE));
        end
        Enable = 1'b1;
        repeat (3) tick();
        chk3("after_fall", 1'b0, 1'b0, 1'b0);

        // Glitch: 10 high, 1 low, then high held.
        for (int k = 1; k <= GLITCH_RISE + 1; k++) begin
            In = (k != 11);
            tick();
            chk3($sformatf("glitch_e%0d", k), (k >= GLITCH_RISE), (k == GLITCH_RISE), 1'b0);
        end

        // Count to 10 toward a fall, then assert reset between edges.
        In = 1'b0;
        for (int k = 1; k <= 10 + S; k++) begin
            tick();
            chk3($sformatf("precount_e%0d", k), 1'b1, 1'b0, 1'b0);
        end
        #2;
        Reset = 1'b0;
        #1;
        chk3("async_reset", 1'b0, 1'b0, 1'b0);
        In = 1'b1;
        repeat (2) begin
            tick();
            chk3("held_reset", 1'b0, 1'b0, 1'b0);
        end
        Reset = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk3($sformatf("post_reset_e%0d", k), (k >= LAT), (k == LAT), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
